// File: rtl/jk_latch_bank_ctrl_pkg.sv
// Shared types for the JK latch bank sequencer: op codes and FSM states.
package jk_latch_bank_ctrl_pkg;

  // Op code is the {J,K} pair driven onto the shared latch bus.
  typedef enum logic [1:0] {
    OP_HOLD   = 2'b00,
    OP_RESET  = 2'b01,
    OP_SET    = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  // SETUP settles J/K, PULSE fires the enable, HOLD keeps J/K stable and samples Q.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SETUP = 2'b01,
    ST_PULSE = 2'b10,
    ST_HOLD  = 2'b11
  } state_e;

endpackage

// File: rtl/jk_latch_bank_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that did not win last time wins.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  logic last_grant;

  // Grant decode: a lone requester always wins, a tie goes away from last_grant.
  always_comb begin
    grant = valid;
    if (&valid) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

  // Remember the winner of each accepted op; reset favours requester 0 first.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= grant[1];
    end
  end

endmodule

// File: rtl/jk_latch_bank_ctrl.sv
// Sequencer for a bank of level-sensitive JK latches on a shared J/K bus.
// Each op runs SETUP -> PULSE -> HOLD so the enable is a single registered
// cycle with J/K already stable, which keeps TOGGLE from racing.
module jk_latch_bank_ctrl
  import jk_latch_bank_ctrl_pkg::*;
#(
  parameter int N_LATCH = 4,
  parameter int ADDR_W  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [ADDR_W-1:0]  req0_addr,
  input  logic [1:0]         req0_op,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [ADDR_W-1:0]  req1_addr,
  input  logic [1:0]         req1_op,
  output logic               latch_j,
  output logic               latch_k,
  output logic [N_LATCH-1:0] latch_en,
  input  logic [N_LATCH-1:0] latch_q,
  output logic               resp_valid,
  output logic               resp_id,
  output logic               resp_q,
  output logic               resp_err
);

  localparam int ADDR_SPAN = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] N_LATCH_W = (ADDR_W + 1)'(N_LATCH);

  state_e                state_q;
  state_e                state_d;
  logic [1:0]            arb_valid;
  logic [1:0]            grant;
  logic                  accept;
  logic [ADDR_W-1:0]     sel_addr;
  op_e                   sel_op;
  logic [ADDR_W-1:0]     cmd_addr;
  op_e                   cmd_op;
  logic                  cmd_id;
  logic                  addr_ok;
  logic [ADDR_SPAN-1:0]  en_full;
  logic [ADDR_SPAN-1:0]  q_full;
  logic [N_LATCH-1:0]    en_mask;

  // Requests are only visible to the arbiter while idle; everything else is ignored.
  assign arb_valid  = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign accept     = |grant;
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign sel_addr   = grant[1] ? req1_addr : req0_addr;
  assign sel_op     = grant[1] ? op_e'(req1_op) : op_e'(req0_op);
  assign addr_ok    = ({1'b0, cmd_addr} < N_LATCH_W);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (arb_valid),
    .accept (accept),
    .grant  (grant)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one lap IDLE -> SETUP -> PULSE -> HOLD -> IDLE per accepted op.
  always_comb begin
    // NOTE: the default assignment first guarantees no path leaves state_d
    // unassigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_SETUP;
      ST_SETUP: state_d = ST_PULSE;
      ST_PULSE: state_d = ST_HOLD;
      ST_HOLD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Enable decode: one-hot on the target latch, nothing for HOLD or an out-of-range address.
  always_comb begin
    en_full = '0;
    if (cmd_op != OP_HOLD) begin
      en_full[cmd_addr] = 1'b1;
    end
    en_mask = addr_ok ? en_full[N_LATCH-1:0] : '0;
  end

  // Widen Q to the full address span so unpopulated addresses read back as 0.
  always_comb begin
    q_full               = '0;
    q_full[N_LATCH-1:0]  = latch_q;
  end

  // Command register, J/K bus, registered enable pulse and response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_addr   <= '0;
      cmd_op     <= OP_HOLD;
      cmd_id     <= 1'b0;
      latch_j    <= 1'b0;
      latch_k    <= 1'b0;
      latch_en   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_q     <= 1'b0;
      resp_err   <= 1'b0;
    end else begin
      latch_en   <= '0;
      resp_valid <= 1'b0;
      resp_id    <= 1'b0;
      resp_q     <= 1'b0;
      resp_err   <= 1'b0;
      if (accept) begin
        cmd_addr <= sel_addr;
        cmd_op   <= sel_op;
        cmd_id   <= grant[1];
        latch_j  <= sel_op[1];
        latch_k  <= sel_op[0];
      end
      if (state_q == ST_SETUP) begin
        latch_en <= en_mask;
      end
      if (state_q == ST_HOLD) begin
        resp_valid <= 1'b1;
        resp_id    <= cmd_id;
        resp_q     <= q_full[cmd_addr] & addr_ok;
        resp_err   <= ~addr_ok;
      end
    end
  end

endmodule

// File: tb/tb_jk_latch_bank_ctrl.sv
// Bench for jk_latch_bank_ctrl: table-driven single ops, a dual-requester
// arbitration run, an out-of-range address on a 3-latch instance and a reset abort.
module tb_jk_latch_bank_ctrl;
  import jk_latch_bank_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_addr, req1_addr, req0_op, req1_op;
  logic       req0_ready, req1_ready;
  logic       latch_j, latch_k;
  logic [3:0] latch_en, latch_q;
  logic       resp_valid, resp_id, resp_q, resp_err;

  logic       r3_ready0, r3_ready1, j3, k3;
  logic [2:0] en3, q3;
  logic       rv3, rid3, rq3, rerr3;

  always #5 clk = ~clk;

  jk_latch_bank_ctrl #(.N_LATCH(4), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_op(req1_op),
    .latch_j(latch_j), .latch_k(latch_k), .latch_en(latch_en), .latch_q(latch_q),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_q(resp_q), .resp_err(resp_err)
  );

  jk_latch_bank_ctrl #(.N_LATCH(3), .ADDR_W(2)) dut3 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r3_ready0), .req0_addr(req0_addr), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(r3_ready1), .req1_addr(req1_addr), .req1_op(req1_op),
    .latch_j(j3), .latch_k(k3), .latch_en(en3), .latch_q(q3),
    .resp_valid(rv3), .resp_id(rid3), .resp_q(rq3), .resp_err(rerr3)
  );

  // All populated latches read 1 so an out-of-range read that leaked would show.
  assign q3 = 3'b111;

  // Bank model: a latch applies its op once for each enable pulse.
  logic [3:0] bank = 4'b0000;
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (latch_en[i] === 1'b1) begin
        case ({latch_j, latch_k})
          2'b01:   bank[i] <= 1'b0;
          2'b10:   bank[i] <= 1'b1;
          2'b11:   bank[i] <= ~bank[i];
          default: ;
        endcase
      end
    end
  end
  assign latch_q = bank;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic jk_next(input logic q, input op_e op);
    case (op)
      OP_HOLD:  return q;
      OP_RESET: return 1'b0;
      OP_SET:   return 1'b1;
      default:  return ~q;
    endcase
  endfunction

  // Scoreboard of responses, pushed at accept and popped when resp_valid shows.
  typedef struct {
    logic id;
    logic q;
    logic err;
    int   due;
  } resp_t;

  resp_t sb[$];
  resp_t sb_head;
  bit    mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (resp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          check("resp_unexpected", 32'd1, 32'd0);
        end else begin
          sb_head = sb.pop_front();
          check("resp_id", resp_id, sb_head.id);
          check("resp_q", resp_q, sb_head.q);
          check("resp_err", resp_err, sb_head.err);
          check("resp_cycle", cyc, sb_head.due);
        end
      end else begin
        check("resp_zero_when_idle", {resp_valid, resp_id, resp_q, resp_err}, 32'd0);
      end
    end
  end

  typedef struct {
    logic       id;
    logic [1:0] addr;
    op_e        op;
    logic [3:0] en;
    logic       q;
  } vec_t;

  typedef struct {
    logic [1:0] addr;
    op_e        op;
  } op_t;

  vec_t       vecs[10];
  vec_t       err_vec;
  op_t        s0[3];
  op_t        s1[3];
  logic [3:0] exp_bank = 4'b0000;
  int         seen3;

  task automatic drive(input logic id, input logic v, input logic [1:0] a, input op_e op);
    if (id) begin
      req1_valid = v; req1_addr = a; req1_op = op;
    end else begin
      req0_valid = v; req0_addr = a; req0_op = op;
    end
  endtask

  // One op from one requester; called at a negedge, returns at the negedge of the response.
  task automatic run_single(input vec_t v);
    int   waited = 0;
    logic rdy;
    drive(v.id, 1'b1, v.addr, v.op);
    #1;
    rdy = v.id ? req1_ready : req0_ready;
    while (rdy !== 1'b1 && waited < 16) begin
      @(negedge clk); #1;
      rdy = v.id ? req1_ready : req0_ready;
      waited++;
    end
    check("ready_seen", rdy, 1'b1);
    if (rdy !== 1'b1) begin
      drive(v.id, 1'b0, v.addr, v.op);
      return;
    end
    check("other_ready_low", v.id ? req0_ready : req1_ready, 1'b0);
    sb.push_back('{v.id, v.q, 1'b0, cyc + 4});
    exp_bank[v.addr] = jk_next(exp_bank[v.addr], v.op);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) drive(v.id, 1'b0, v.addr, v.op);
      check("latch_en", latch_en, (k == 2) ? v.en : 4'b0000);
      if (k <= 3) begin
        check("jk_bus", {latch_j, latch_k}, v.op);
        check("ready_busy", {req1_ready, req0_ready}, 2'b00);
      end
    end
  endtask

  initial begin
    int  i0, i1, last_acc, n_acc, guard;
    logic gid, expect_id, nq;
    op_t cur;

    vecs[0] = '{1'b0, 2'd2, OP_SET,    4'b0100, 1'b1};
    vecs[1] = '{1'b0, 2'd2, OP_TOGGLE, 4'b0100, 1'b0};
    vecs[2] = '{1'b1, 2'd1, OP_SET,    4'b0010, 1'b1};
    vecs[3] = '{1'b0, 2'd1, OP_HOLD,   4'b0000, 1'b1};
    vecs[4] = '{1'b1, 2'd1, OP_RESET,  4'b0010, 1'b0};
    vecs[5] = '{1'b1, 2'd3, OP_TOGGLE, 4'b1000, 1'b1};
    vecs[6] = '{1'b0, 2'd3, OP_TOGGLE, 4'b1000, 1'b0};
    vecs[7] = '{1'b0, 2'd0, OP_SET,    4'b0001, 1'b1};
    vecs[8] = '{1'b1, 2'd2, OP_HOLD,   4'b0000, 1'b0};
    vecs[9] = '{1'b0, 2'd0, OP_RESET,  4'b0001, 1'b0};
    err_vec = '{1'b0, 2'd3, OP_SET,    4'b1000, 1'b1};
    s0[0] = '{2'd0, OP_SET};  s0[1] = '{2'd0, OP_TOGGLE}; s0[2] = '{2'd3, OP_HOLD};
    s1[0] = '{2'd2, OP_TOGGLE}; s1[1] = '{2'd3, OP_RESET}; s1[2] = '{2'd2, OP_SET};

    // Reset for three cycles with requester 0 already waiting.
    rst = 1'b1;
    drive(1'b0, 1'b1, 2'd0, OP_HOLD);
    drive(1'b1, 1'b0, 2'd0, OP_HOLD);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_latch_en", latch_en, 4'b0000);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_jk", {latch_j, latch_k}, 2'b00);
    check("rst_ready0", req0_ready, 1'b1);
    check("rst_ready1", req1_ready, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 2'd0, OP_HOLD);
    mon_en = 1'b1;

    // Table of single ops, back to back.
    for (int v = 0; v < 10; v++) run_single(vecs[v]);

    // Out-of-range address on the 3-latch instance: error response, no enable.
    seen3 = 0;
    fork
      run_single(err_vec);
      begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          check("en3_off", en3, 3'b000);
          if (rv3 === 1'b1) begin
            seen3++;
            check("err3_flag", rerr3, 1'b1);
            check("err3_q", rq3, 1'b0);
            check("err3_id", rid3, 1'b0);
          end
        end
        check("err3_resp_count", seen3, 1);
      end
    join

    // Reset during PULSE: enable drops at the next edge and no response follows.
    drive(1'b0, 1'b1, 2'd1, OP_SET);
    #1;
    check("abort_ready", req0_ready, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'd1, OP_SET);
    @(negedge clk);
    check("abort_pulse_en", latch_en, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    check("abort_en_cleared", latch_en, 4'b0000);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_no_resp_pending", sb.size(), 0);

    // Both requesters valid: grants alternate 0,1,... spaced four cycles apart.
    i0 = 0; i1 = 0; last_acc = 0; n_acc = 0; guard = 0; expect_id = 1'b0;
    while ((i0 < 3 || i1 < 3) && guard < 100) begin
      req0_valid = (i0 < 3);
      if (i0 < 3) begin req0_addr = s0[i0].addr; req0_op = s0[i0].op; end
      req1_valid = (i1 < 3);
      if (i1 < 3) begin req1_addr = s1[i1].addr; req1_op = s1[i1].op; end
      #1;
      if (req0_ready === 1'b1 || req1_ready === 1'b1) begin
        gid = req1_ready;
        check("dual_single_ready", req0_ready & req1_ready, 1'b0);
        check("dual_grant_order", gid, expect_id);
        if (n_acc > 0) check("dual_spacing", cyc - last_acc, 4);
        last_acc = cyc;
        n_acc++;
        cur = gid ? s1[i1] : s0[i0];
        nq = jk_next(exp_bank[cur.addr], cur.op);
        exp_bank[cur.addr] = nq;
        sb.push_back('{gid, nq, 1'b0, cyc + 4});
        if (gid) i1++; else i0++;
        expect_id = ~expect_id;
      end
      @(negedge clk);
      guard++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("dual_all_accepted", n_acc, 6);

    repeat (6) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
